// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point multiplier: default
// format widths, the controller state encoding and default-format constants.
package fp_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 7;
    localparam int DEF_SIG_W = DEF_MAN_W + 1;
    localparam int DEF_W     = 1 + DEF_EXP_W + DEF_MAN_W;
    localparam int DEF_BIAS  = 2**(DEF_EXP_W-1) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    // Default-format (bfloat16) special encodings
    localparam logic [DEF_EXP_W-1:0] EXP_ONES_DEF = {DEF_EXP_W{1'b1}};
    localparam logic [DEF_W-1:0]     QNAN_DEF     = {1'b0, EXP_ONES_DEF, 1'b1, {(DEF_MAN_W-1){1'b0}}};
    localparam logic [DEF_W-1:0]     INF_DEF      = {1'b0, EXP_ONES_DEF, {DEF_MAN_W{1'b0}}};

endpackage

// File: rtl/fp_mul_norm_round.sv
// Combinational back end of the multiplier: normalises the raw significand
// product, rounds to nearest-even, finishes the exponent and resolves the
// special result classes into a packed result plus exception flags.
module fp_mul_norm_round
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic [2*(MAN_W+1)-1:0]  product,
    input  logic signed [EXP_W+1:0] e_raw,
    input  logic                    sign,
    input  logic                    is_nan,
    input  logic                    is_inv,
    input  logic                    is_inf,
    input  logic                    is_zero,
    output logic [EXP_W+MAN_W:0]    result,
    output logic                    flag_ovf,
    output logic                    flag_unf,
    output logic                    flag_inv
);

    localparam int SIG_W = MAN_W + 1;
    localparam int EW    = EXP_W + 2;

    localparam logic [EXP_W-1:0]        EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W+MAN_W:0]    QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW-1:0]    E_MAX    = EW'((2**EXP_W) - 1);

    logic                    norm;
    logic [2*SIG_W-2:0]      shifted;
    logic [MAN_W-1:0]        man_t;
    logic                    guard;
    logic                    sticky;
    logic                    inc;
    logic [MAN_W:0]          man_sum;
    logic                    carry;
    logic signed [EW-1:0]    e_fin;
    logic [MAN_W-1:0]        man_fin;

    // A product in [2,4) already has its leading one at the top; otherwise
    // shift left once so the leading one always sits just above the mantissa.
    assign norm    = product[2*SIG_W-1];
    assign shifted = norm ? product[2*SIG_W-2:0] : {product[2*SIG_W-3:0], 1'b0};

    assign man_t   = shifted[2*SIG_W-2:SIG_W];
    assign guard   = shifted[SIG_W-1];
    assign sticky  = |shifted[SIG_W-2:0];
    assign inc     = guard & (sticky | man_t[0]);
    assign man_sum = {1'b0, man_t} + {{MAN_W{1'b0}}, inc};
    assign carry   = man_sum[MAN_W];
    assign man_fin = carry ? {MAN_W{1'b0}} : man_sum[MAN_W-1:0];

    // Exponent gets +1 for a [2,4) product and +1 more if rounding carried out
    assign e_fin   = e_raw + signed'(EW'(norm)) + signed'(EW'(carry));

    // Resolve result class in priority order: NaN, inf*0, inf, zero, ovf, unf
    always_comb begin
        result   = {sign, e_fin[EXP_W-1:0], man_fin};
        flag_ovf = 1'b0;
        flag_unf = 1'b0;
        flag_inv = 1'b0;
        if (is_nan) begin
            result   = QNAN;
            flag_inv = 1'b1;
        end else if (is_inv) begin
            result   = QNAN;
            flag_inv = 1'b1;
        end else if (is_inf) begin
            result   = {sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (is_zero) begin
            result   = {sign, {(EXP_W+MAN_W){1'b0}}};
        end else if (e_fin >= E_MAX) begin
            result   = {sign, EXP_ONES, {MAN_W{1'b0}}};
            flag_ovf = 1'b1;
        end else if (e_fin[EW-1] || (e_fin == '0)) begin
            result   = {sign, {(EXP_W+MAN_W){1'b0}}};
            flag_unf = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential floating-point multiplier: accepts two packed operands through a
// valid/ready handshake, forms the significand product with a one-bit-per-cycle
// shift-add loop, then normalises/rounds in a single cycle and holds the
// packed result and flags until the consumer takes them.
module fp_mul_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int BIAS  = 2**(EXP_W-1) - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 flag_ovf,
    output logic                 flag_unf,
    output logic                 flag_inv
);

    localparam int SIG_W = MAN_W + 1;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int EW    = EXP_W + 2;
    localparam int CNT_W = (SIG_W > 2) ? $clog2(SIG_W) : 1;

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIG_W - 1);

    state_t               state;
    state_t               next_state;

    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic [SIG_W-1:0]     mplier_q;
    logic [2*SIG_W-1:0]   acc_q;
    logic [CNT_W-1:0]     count_q;
    logic [W-1:0]         result_q;
    logic                 ovf_q;
    logic                 unf_q;
    logic                 inv_q;

    logic                 accept;
    logic [SIG_W-1:0]     sig_b_in;

    logic                 sa, sb;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     ma, mb;
    logic [SIG_W-1:0]     sig_a;
    logic [SIG_W:0]       partial;

    logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic                 is_nan, is_inv, is_inf, is_zero;
    logic signed [EW-1:0] e_raw;

    logic [W-1:0]         nr_result;
    logic                 nr_ovf, nr_unf, nr_inv;

    assign accept   = in_valid && in_ready;
    assign sig_b_in = {|b[W-2:MAN_W], b[MAN_W-1:0]};

    assign sa    = a_q[W-1];
    assign sb    = b_q[W-1];
    assign ea    = a_q[W-2:MAN_W];
    assign eb    = b_q[W-2:MAN_W];
    assign ma    = a_q[MAN_W-1:0];
    assign mb    = b_q[MAN_W-1:0];
    assign sig_a = {|ea, ma};

    // Add the multiplicand into the upper half when the current multiplier bit is set
    assign partial = {1'b0, acc_q[2*SIG_W-1:SIG_W]} + (mplier_q[0] ? {1'b0, sig_a} : '0);

    // Operand classification; exponent zero (denormal) counts as zero
    assign a_nan  = (ea == EXP_ONES) && (ma != '0);
    assign b_nan  = (eb == EXP_ONES) && (mb != '0);
    assign a_inf  = (ea == EXP_ONES) && (ma == '0);
    assign b_inf  = (eb == EXP_ONES) && (mb == '0);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

    assign is_nan  = a_nan || b_nan;
    assign is_inv  = (a_inf && b_zero) || (b_inf && a_zero);
    assign is_inf  = a_inf || b_inf;
    assign is_zero = a_zero || b_zero;

    assign e_raw = signed'({2'b00, ea}) + signed'({2'b00, eb}) - signed'(EW'(BIAS));

    fp_mul_norm_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm_round (
        .product  (acc_q),
        .e_raw    (e_raw),
        .sign     (sa ^ sb),
        .is_nan   (is_nan),
        .is_inv   (is_inv),
        .is_inf   (is_inf),
        .is_zero  (is_zero),
        .result   (nr_result),
        .flag_ovf (nr_ovf),
        .flag_unf (nr_unf),
        .flag_inv (nr_inv)
    );

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Controller next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept)               next_state = MUL;
            MUL:  if (count_q == CNT_LAST)  next_state = NORM;
            NORM:                           next_state = DONE;
            DONE: if (out_ready)            next_state = IDLE;
            default:                        next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: operand capture, shift-add iteration and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q      <= a;
                        b_q      <= b;
                        mplier_q <= sig_b_in;
                        acc_q    <= '0;
                        count_q  <= '0;
                        result_q <= '0;
                        ovf_q    <= 1'b0;
                        unf_q    <= 1'b0;
                        inv_q    <= 1'b0;
                    end
                end
                MUL: begin
                    acc_q    <= {partial, acc_q[SIG_W-1:1]};
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CNT_W'(1);
                end
                NORM: begin
                    result_q <= nr_result;
                    ovf_q    <= nr_ovf;
                    unf_q    <= nr_unf;
                    inv_q    <= nr_inv;
                end
                default: ;
            endcase
        end
    end

    assign result   = result_q;
    assign flag_ovf = ovf_q;
    assign flag_unf = unf_q;
    assign flag_inv = inv_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed testbench for fp_mul_seq in its default bfloat16 configuration.
module tb_fp_mul_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_inv;

    int vectors;
    int miscompares;

    fp_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
        .flag_inv  (flag_inv)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction: accept, latency, result/flags, optional backpressure, release
    task automatic applyStimulus(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                                 input logic [15:0] exp_res, input logic [2:0] exp_flags,
                                 input int hold);
        int cycles;
        @(posedge clk); #1;
        checkOutput({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 16'h0;
        b        = 16'h0;
        cycles   = 0;
        while (!out_valid && cycles < 30) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput({tag, ".latency"}, 32'(cycles), 32'd9);
        checkOutput({tag, ".result"}, 32'(result), 32'(exp_res));
        checkOutput({tag, ".flags"}, 32'({flag_ovf, flag_unf, flag_inv}), 32'(exp_flags));
        checkOutput({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            a        = 16'h3F80;
            b        = 16'h3F80;
            in_valid = 1'b1;
            @(posedge clk); #1;
            checkOutput({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, ".hold_result"}, 32'(result), 32'(exp_res));
            checkOutput({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, ".release_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ".release_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.result", 32'(result), 32'd0);
        checkOutput("reset.flags", 32'({flag_ovf, flag_unf, flag_inv}), 32'd0);

        // flags argument is {ovf, unf, inv}
        applyStimulus("mul_1p5x1p5", 16'h3FC0, 16'h3FC0, 16'h4010, 3'b000, 0);
        applyStimulus("mul_1xm2",    16'h3F80, 16'hC000, 16'hC000, 3'b000, 0);
        applyStimulus("rne_tie_up",  16'h3F81, 16'h3FC0, 16'h3FC2, 3'b000, 0);
        applyStimulus("overflow",    16'h7F00, 16'h4000, 16'h7F80, 3'b100, 0);
        applyStimulus("underflow",   16'h0080, 16'h3F00, 16'h0000, 3'b010, 0);
        applyStimulus("inf_x_zero",  16'h7F80, 16'h0000, 16'h7FC0, 3'b001, 0);
        applyStimulus("nan_in",      16'h7FC1, 16'h3F80, 16'h7FC0, 3'b001, 0);
        applyStimulus("neg_zero",    16'h8000, 16'h4000, 16'h8000, 3'b000, 0);
        applyStimulus("backpress",   16'h3FC0, 16'h4000, 16'h4040, 3'b000, 5);

        // Abort an operation with reset during the fourth multiply cycle
        @(posedge clk); #1;
        a        = 16'h3FC0;
        b        = 16'h3FC0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort.in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort.out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort.result", 32'(result), 32'd0);

        applyStimulus("after_abort", 16'h4000, 16'h4000, 16'h4080, 3'b000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
